// File: rtl/alu_pipe.sv
// alu_pipe: valid/ready ALU with single-cycle AND/OR/ADD/SUB/XOR/SLT and an optional shift-add MUL.
// Define ALU_PIPE_MUL_EN to build the iterative multiplier; otherwise opcode 1000 reports illegal.
module alu_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  input  logic [3:0]       ALU_control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALU_result,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic             illegal
);
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_XOR = 4'b0011;
  localparam logic [3:0] OP_SLT = 4'b0111;

`ifdef ALU_PIPE_MUL_EN
  localparam logic [3:0] OP_MUL = 4'b1000;
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd2} state_t;
`endif

  state_t           state, state_nxt;
  logic             ready_en;
  logic             accept;
  logic             sub;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c, alu_v, alu_ill;
  logic [WIDTH-1:0] result_q;
  logic             zero_q, carry_q, ovf_q, ill_q;

  // ready_en keeps in_ready low through reset and until the first edge after release
  assign in_ready  = ready_en && ((state == IDLE) || ((state == DONE) && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == DONE);

  assign ALU_result = result_q;
  assign zero       = zero_q;
  assign carry      = carry_q;
  assign overflow   = ovf_q;
  assign illegal    = ill_q;

  // SUB reuses the adder as A + ~B + 1 so carry means "no borrow"
  assign sub   = (ALU_control == OP_SUB);
  assign b_eff = sub ? ~data2 : data2;
  assign sum   = {1'b0, data1} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};

`ifdef ALU_PIPE_MUL_EN
  logic             start_mul;
  logic             mul_last;
  logic [WIDTH-1:0] mcand, mplier, acc, acc_nxt;
  logic [CW-1:0]    cnt;

  assign acc_nxt  = acc + (mplier[0] ? mcand : '0);
  assign mul_last = (cnt == CW'(WIDTH - 1));
`endif

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_ill = 1'b0;
`ifdef ALU_PIPE_MUL_EN
    start_mul = 1'b0;
`endif
    case (ALU_control)
      OP_AND: alu_res = data1 & data2;
      OP_OR:  alu_res = data1 | data2;
      OP_XOR: alu_res = data1 ^ data2;
      OP_ADD, OP_SUB: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (data1[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != data1[WIDTH-1]);
      end
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(data1) < $signed(data2))};
`ifdef ALU_PIPE_MUL_EN
      OP_MUL: start_mul = 1'b1;
`endif
      default: alu_ill = 1'b1;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = DONE;
`ifdef ALU_PIPE_MUL_EN
      BUSY: if (mul_last) state_nxt = DONE;
`endif
      DONE: if (out_ready) state_nxt = accept ? DONE : IDLE;
      default: state_nxt = IDLE;
    endcase
`ifdef ALU_PIPE_MUL_EN
    if (accept && start_mul) state_nxt = BUSY;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      ill_q    <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (accept) begin
        result_q <= alu_res;
        zero_q   <= (alu_res == '0);
        carry_q  <= alu_c;
        ovf_q    <= alu_v;
        ill_q    <= alu_ill;
      end
`ifdef ALU_PIPE_MUL_EN
      if ((state == BUSY) && mul_last) begin
        result_q <= acc_nxt;
        zero_q   <= (acc_nxt == '0);
        carry_q  <= 1'b0;
        ovf_q    <= 1'b0;
        ill_q    <= 1'b0;
      end
`endif
    end
  end

`ifdef ALU_PIPE_MUL_EN
  // One partial product per BUSY cycle: multiplicand walks left, multiplier walks right
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (accept && start_mul) begin
      mcand  <= data1;
      mplier <= data2;
      acc    <= '0;
      cnt    <= '0;
    end else if (state == BUSY) begin
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      acc    <= acc_nxt;
      cnt    <= cnt + CW'(1);
    end
  end
`endif

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe (WIDTH=8): directed cases plus randomized ops against an arithmetic reference model.
module tb_alu_pipe;
  localparam int W    = 8;
  localparam int MOD  = 1 << W;
  localparam int HALF = 1 << (W - 1);

  logic         clk, rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] data1, data2, ALU_result;
  logic [3:0]   ctl;
  logic         zero, carry, overflow, illegal;

  int errors, checks;

  alu_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .data1(data1), .data2(data2), .ALU_control(ctl),
    .out_valid(out_valid), .out_ready(out_ready), .ALU_result(ALU_result),
    .zero(zero), .carry(carry), .overflow(overflow), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model(input int op, input int a, input int b,
                                output int r, output int c, output int v, output int il);
    int sa, sb, s;
    sa = (a >= HALF) ? a - MOD : a;
    sb = (b >= HALF) ? b - MOD : b;
    r = 0; c = 0; v = 0; il = 0;
    case (op)
      0: r = a & b;
      1: r = a | b;
      3: r = a ^ b;
      2: begin
        s = a + b; r = s % MOD; c = int'(s >= MOD);
        v = int'((sa + sb) >= HALF || (sa + sb) < -HALF);
      end
      6: begin
        s = a + (MOD - 1 - b) + 1; r = s % MOD; c = int'(s >= MOD);
        v = int'((sa - sb) >= HALF || (sa - sb) < -HALF);
      end
      7: r = int'(sa < sb);
`ifdef ALU_PIPE_MUL_EN
      8: r = (a * b) % MOD;
`endif
      default: il = 1;
    endcase
  endfunction

  task automatic chk_out(input string tag, input int op, input int a, input int b);
    int r, c, v, il;
    model(op, a, b, r, c, v, il);
    chk({tag, ".vld"}, out_valid, 1);
    chk({tag, ".res"}, ALU_result, r);
    chk({tag, ".zero"}, zero, int'(r == 0));
    chk({tag, ".carry"}, carry, c);
    chk({tag, ".ovf"}, overflow, v);
    chk({tag, ".ill"}, illegal, il);
  endtask

  // Starts at a falling edge with the DUT idle; leaves it idle at a falling edge.
  task automatic run_op(input string tag, input int op, input int a, input int b, input int stall);
    int lat, expl;
    expl = 1;
`ifdef ALU_PIPE_MUL_EN
    if (op == 8) expl = W + 1;
`endif
    chk({tag, ".rdy"}, in_ready, 1);
    in_valid = 1'b1; ctl = 4'(op); data1 = 8'(a); data2 = 8'(b);
    out_ready = (stall == 0);
    @(negedge clk);
    in_valid = 1'b0; data1 = 8'($urandom); data2 = 8'($urandom); ctl = 4'($urandom);
    lat = 1;
    while (!out_valid && lat < 64) begin
      chk({tag, ".busy_rdy"}, in_ready, 0);
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      lat++;
    end
    chk({tag, ".lat"}, lat, expl);
    chk_out(tag, op, a, b);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk_out({tag, ".hold"}, op, a, b);
      chk({tag, ".hold_rdy"}, in_ready, 0);
    end
    if (stall > 0) begin
      out_ready = 1'b1;
      #1 chk({tag, ".rel_rdy"}, in_ready, 1);
    end
    @(negedge clk);
    chk({tag, ".drain"}, out_valid, 0);
  endtask

  initial begin
    int op, a, b;
    int edges[4];
    edges[0] = 0; edges[1] = 'h7F; edges[2] = 'h80; edges[3] = 'hFF;
    errors = 0; checks = 0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; data1 = '0; data2 = '0; ctl = '0;
    repeat (2) @(negedge clk);
    chk("rst.vld", out_valid, 0);
    chk("rst.res", ALU_result, 0);
    chk("rst.zero", zero, 0);
    chk("rst.carry", carry, 0);
    chk("rst.ovf", overflow, 0);
    chk("rst.ill", illegal, 0);
    chk("rst.rdy", in_ready, 0);
    rst_n = 1'b1;
    #1 chk("rel.rdy_before_edge", in_ready, 0);
    @(negedge clk);
    chk("rel.rdy_after_edge", in_ready, 1);

    run_op("add_7f_01", 2, 'h7F, 'h01, 0);
    run_op("sub_5_5", 6, 'h05, 'h05, 0);
    run_op("sub_0_1", 6, 'h00, 'h01, 0);
    run_op("and_stall", 0, 'hF0, 'h3C, 5);
    run_op("mul_d_b", 8, 'h0D, 'h0B, 0);
    run_op("mul_ff_ff", 8, 'hFF, 'hFF, 2);
    run_op("illegal_f", 15, 'h12, 'h34, 1);
    run_op("slt_eq", 7, 'h80, 'h80, 0);

    // back-to-back single-cycle ops at full throughput
    out_ready = 1'b1;
    in_valid = 1'b1; ctl = 4'd1; data1 = 8'hA5; data2 = 8'h0F;
    @(negedge clk);
    chk_out("b2b_or", 1, 'hA5, 'h0F);
    chk("b2b_or.rdy", in_ready, 1);
    ctl = 4'd3; data1 = 8'hA5; data2 = 8'hFF;
    @(negedge clk);
    chk_out("b2b_xor", 3, 'hA5, 'hFF);
    ctl = 4'd7; data1 = 8'h80; data2 = 8'h01;
    @(negedge clk);
    chk_out("b2b_slt", 7, 'h80, 'h01);
    in_valid = 1'b0;
    @(negedge clk);
    chk("b2b.drain", out_valid, 0);

    for (int i = 0; i < 80; i++) begin
      op = $urandom_range(0, 8);
      case (op)
        4: op = 6;
        5: op = 7;
        8: op = ($urandom_range(0, 1) == 1) ? 8 : int'($urandom_range(0, 15));
        default: ;
      endcase
      a = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 3)] : int'($urandom_range(0, 255));
      b = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 3)] : int'($urandom_range(0, 255));
      run_op("rand", op, a, b, int'($urandom_range(0, 3)));
    end

    // reset in the middle of an operation discards it
    out_ready = 1'b1;
`ifdef ALU_PIPE_MUL_EN
    in_valid = 1'b1; ctl = 4'd8; data1 = 8'h0D; data2 = 8'h0B;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
`else
    out_ready = 1'b0;
    in_valid = 1'b1; ctl = 4'd2; data1 = 8'h09; data2 = 8'h09;
    @(negedge clk);
    in_valid = 1'b0;
    chk("mid.vld_before", out_valid, 1);
`endif
    #2 rst_n = 1'b0;
    #1;
    chk("mid.vld", out_valid, 0);
    chk("mid.res", ALU_result, 0);
    chk("mid.zero", zero, 0);
    chk("mid.carry", carry, 0);
    chk("mid.ovf", overflow, 0);
    chk("mid.ill", illegal, 0);
    chk("mid.rdy", in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (W + 2) begin
      @(negedge clk);
      chk("mid.no_vld", out_valid, 0);
    end
    run_op("post_rst_add", 2, 2, 3, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
